rs_complex: RTL and testbench
=============================

// Module: rs_complex
// PURPOSE
//  Two-entry reservation station feeding the complex execution unit; producer side of the rs_complex_0/1 + *_issue interface.
//  - Accepts one dispatched instruction per cycle.
//  - Holds operands until both are ready, capturing missing operands from two writeback broadcast buses.
//  - Presents both entries plus an age selector to the complex unit; frees a slot when that unit pulses its issue.
// PARAMETERS
//  ENTRY_W  114  packed entry width: memdata[113:82] aluop[81:76] memwrite[75] memread[74] memtoreg[73] branch[72]
//                regwrite[71] op2[70:39] op2_rdy[38] op1[37:6] op1_rdy[5] rd[4:0]
//  DATA_W   32   operand/broadcast data width
//  TAG_W    4    ROB tag width; a not-ready operand holds its producer tag in op[TAG_W-1:0]
// PORTS
//  clk                    in   1        clock
//  rst_n                  in   1        asynchronous active-low reset
//  dispatch_valid         in   1        dispatch request this cycle
//  dispatch_entry         in   ENTRY_W  packed entry, same layout as above
//  dispatch_rob_num       in   TAG_W    ROB slot of the dispatched instruction
//  rs_full                out  1        both slots occupied; dispatch_valid is ignored while high
//  cdb0_valid/cdb1_valid  in   1        writeback broadcast valid (simple / complex unit)
//  cdb0_tag/cdb1_tag      in   TAG_W    ROB tag of broadcast result
//  cdb0_data/cdb1_data    in   DATA_W   broadcast result
//  flush                  in   1        mispredict flush: invalidate all entries
//  complex_0_issue        in   1        slot 0 consumed this cycle
//  complex_1_issue        in   1        slot 1 consumed this cycle
//  rs_complex_0/1         out  ENTRY_W  slot contents; all-zero when the slot is empty
//  rs_complex_0/1_entry_num out TAG_W   ROB slot of each entry (0 when empty)
//  selector               out  1        index of the NEWER slot; consumer picks !selector when both are ready
// BEHAVIOUR
//  - Reset: both slots invalid; rs_complex_*, *_entry_num, selector and rs_full all 0.
//  - Slot outputs are registered; empty slots drive zeros so both ready bits read 0.
//  - Dispatch (dispatch_valid & !rs_full): write the lowest-index free slot at the clock edge; selector <= that index.
//  - Issue: complex_i_issue clears slot i at the clock edge.
//    - Both issue bits high clears both slots.
//    - Issue on an empty slot is a no-op.
//  - Same cycle issue + dispatch: dispatch uses a slot that was free at cycle start. A slot freed this cycle is not
//    reused until the next cycle; rs_full is computed from current occupancy only.
//  - Wakeup: for every valid entry operand with rdy=0, a tag match on cdbX_valid captures cdbX_data and sets rdy=1
//    at the edge. If both buses match, cdb0 wins.
//  - Dispatch bypass: a broadcast in the dispatch cycle whose tag matches a not-ready dispatched operand is captured
//    into the new entry.
//  - Flush: clears both slots and forces selector=0; it has priority over dispatch, issue and wakeup in the same cycle.
//  - Latency: dispatch-to-visible is 1 cycle; ready-to-issue is 0 cycles (consumer is combinational);
//    wakeup-to-ready is 1 cycle.
//  - Reset mid-operation: entries drop immediately and asynchronously; no partial state survives.
// CONFIGURATION
//  RS_COMPLEX_PERF_EN defined:
//    - Adds output perf_issue_cnt[15:0]: counts cycles with any issue bit set, saturating.
//    - Adds output perf_stall_cnt[15:0]: counts cycles with dispatch_valid & rs_full, saturating.
//    - Both counters reset to 0 on rst_n and are unaffected by flush.
//  Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package rs_pkg holds:
//    - Field offset localparams: MEMDATA_HI/LO, ALUOP_HI/LO, MEMWRITE, MEMREAD, MEMTOREG, BRANCH, REGWRITE,
//      OP2_HI/LO, OP2_RDY, OP1_HI/LO, OP1_RDY, RD_HI/LO.
//    - ENTRY_W, DATA_W, TAG_W.
//  - Sub-module rs_operand_wakeup, instantiated 4 times (2 slots x 2 operands):
//    - Takes the operand value, rdy and both CDB buses.
//    - Returns the next value and rdy with cdb0 priority.
// TESTING
//  1. Reset, then dispatch op1_rdy=1 op1=5, op2_rdy=1 op2=7, rob 3
//     -> next cycle rs_complex_0[5]=1, [38]=1, entry_num_0=3, selector=0, rs_full=0.
//  2. Dispatch op2 not ready (tag 9), then cdb1_valid tag 9 data 0xDEAD
//     -> one cycle later op2=0xDEAD and op2_rdy=1. A same-cycle cdb0 tag 9 data 0x1 instead yields 0x1.
//  3. Fill both slots (rob 1, then rob 2)
//     -> rs_full=1, selector=1. A further dispatch is dropped; complex_0_issue frees slot 0 and rs_full falls next cycle.
//  4. Dispatch with cdb0 tag equal to the dispatched op1 tag in the same cycle
//     -> entry appears with op1_rdy=1 holding the broadcast data.
//  5. Both slots full; flush + dispatch_valid + complex_1_issue in one cycle
//     -> all outputs zero next cycle, selector=0.
//  6. Under RS_COMPLEX_PERF_EN: 3 stalled dispatch cycles and 2 issue cycles
//     -> perf_stall_cnt=3 and perf_issue_cnt=2. Preload 0xFFFF -> counter holds 0xFFFF.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared definitions for the complex-unit reservation station.
// Holds the packed entry field offsets, the data/tag widths and the
// writeback broadcast bundle type used by the station and its operand
// wakeup sub-module.
package rs_pkg;
  localparam int ENTRY_W = 114;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;

  localparam int MEMDATA_HI = 113;
  localparam int MEMDATA_LO = 82;
  localparam int ALUOP_HI   = 81;
  localparam int ALUOP_LO   = 76;
  localparam int MEMWRITE   = 75;
  localparam int MEMREAD    = 74;
  localparam int MEMTOREG   = 73;
  localparam int BRANCH     = 72;
  localparam int REGWRITE   = 71;
  localparam int OP2_HI     = 70;
  localparam int OP2_LO     = 39;
  localparam int OP2_RDY    = 38;
  localparam int OP1_HI     = 37;
  localparam int OP1_LO     = 6;
  localparam int OP1_RDY    = 5;
  localparam int RD_HI      = 4;
  localparam int RD_LO      = 0;

  // One writeback broadcast bus.
  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;
endpackage

// File: rtl/rs_operand_wakeup.sv
// Operand wakeup for one source operand.
// A not-ready operand holds its producer tag in its low TAG_W bits; a
// matching broadcast replaces the value and marks it ready. cdb0 wins
// when both buses match. Ready operands pass through untouched.
// Ports:
//   i_val/i_rdy   current operand value and ready bit
//   i_cdb0/i_cdb1 writeback broadcast buses
//   o_val/o_rdy   operand after this cycle's wakeup
module rs_operand_wakeup
  import rs_pkg::*;
(
  input  logic [DATA_W-1:0] i_val,
  input  logic              i_rdy,
  input  cdb_t              i_cdb0,
  input  cdb_t              i_cdb1,
  output logic [DATA_W-1:0] o_val,
  output logic              o_rdy
);
  logic w_hit0, w_hit1;

  assign w_hit0 = !i_rdy && i_cdb0.vld && (i_cdb0.tag == i_val[TAG_W-1:0]);
  assign w_hit1 = !i_rdy && i_cdb1.vld && (i_cdb1.tag == i_val[TAG_W-1:0]);

  always_comb begin
    o_val = i_val;
    o_rdy = i_rdy;
    if (w_hit0) begin
      o_val = i_cdb0.data;
      o_rdy = 1'b1;
    end else if (w_hit1) begin
      o_val = i_cdb1.data;
      o_rdy = 1'b1;
    end
  end
endmodule

// File: rtl/rs_complex.sv
// Two-entry reservation station feeding the complex execution unit.
// Accepts one dispatch per cycle into the lowest free slot, wakes up
// waiting operands from two writeback buses, and presents both slots plus
// an age selector (index of the newer slot) to the consumer, which frees a
// slot by pulsing its issue bit.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   dispatch_valid/entry/rob_num  dispatch request
//   rs_full                       both slots occupied
//   cdb{0,1}_valid/tag/data       writeback broadcasts (cdb0 has priority)
//   flush                         drop everything, selector back to 0
//   complex_{0,1}_issue           slot consumed this cycle
//   rs_complex_{0,1}[_entry_num]  slot contents / ROB slot, zero when empty
//   selector                      index of the newer slot
// Optional feature macro RS_COMPLEX_PERF_EN adds saturating counters
// perf_issue_cnt (cycles with any issue) and perf_stall_cnt (cycles with
// dispatch_valid while full); flush does not touch them.
module rs_complex
  import rs_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dispatch_valid,
  input  logic [ENTRY_W-1:0] dispatch_entry,
  input  logic [TAG_W-1:0]   dispatch_rob_num,
  output logic               rs_full,
  input  logic               cdb0_valid,
  input  logic [TAG_W-1:0]   cdb0_tag,
  input  logic [DATA_W-1:0]  cdb0_data,
  input  logic               cdb1_valid,
  input  logic [TAG_W-1:0]   cdb1_tag,
  input  logic [DATA_W-1:0]  cdb1_data,
  input  logic               flush,
  input  logic               complex_0_issue,
  input  logic               complex_1_issue,
  output logic [ENTRY_W-1:0] rs_complex_0,
  output logic [ENTRY_W-1:0] rs_complex_1,
  output logic [TAG_W-1:0]   rs_complex_0_entry_num,
  output logic [TAG_W-1:0]   rs_complex_1_entry_num,
  output logic               selector
`ifdef RS_COMPLEX_PERF_EN
  ,output logic [15:0]       perf_issue_cnt,
  output logic [15:0]        perf_stall_cnt
`endif
);
  logic [1:0]              r_vld;
  logic [1:0][ENTRY_W-1:0] r_ent;
  logic [1:0][TAG_W-1:0]   r_rob;
  logic                    r_sel;

  cdb_t                    w_cdb0, w_cdb1;
  logic [1:0]              w_tgt, w_iss;
  logic                    w_full, w_dsp;
  logic [1:0][ENTRY_W-1:0] w_base, w_nxt;
  logic [1:0][DATA_W-1:0]  w_op1, w_op2;
  logic [1:0]              w_op1r, w_op2r;

  assign w_cdb0 = {cdb0_valid, cdb0_tag, cdb0_data};
  assign w_cdb1 = {cdb1_valid, cdb1_tag, cdb1_data};
  assign w_iss  = {complex_1_issue, complex_0_issue};

  // Fullness and target slot come from start-of-cycle occupancy only, so a
  // slot freed by this cycle's issue is not reused until the next cycle.
  assign w_full   = &r_vld;
  assign w_dsp    = dispatch_valid & ~w_full;
  assign w_tgt[0] = ~r_vld[0];
  assign w_tgt[1] = r_vld[0] & ~r_vld[1];

  // Each slot's wakeup logic sees either the stored entry or, when the slot
  // is this cycle's dispatch target (and therefore empty), the incoming
  // entry -- which gives the dispatch-cycle broadcast bypass for free.
  for (genvar g = 0; g < 2; g++) begin : g_slot
    assign w_base[g] = (w_dsp && w_tgt[g]) ? dispatch_entry : r_ent[g];

    rs_operand_wakeup u_wk_op1 (
      .i_val (w_base[g][OP1_HI:OP1_LO]),
      .i_rdy (w_base[g][OP1_RDY]),
      .i_cdb0(w_cdb0),
      .i_cdb1(w_cdb1),
      .o_val (w_op1[g]),
      .o_rdy (w_op1r[g])
    );

    rs_operand_wakeup u_wk_op2 (
      .i_val (w_base[g][OP2_HI:OP2_LO]),
      .i_rdy (w_base[g][OP2_RDY]),
      .i_cdb0(w_cdb0),
      .i_cdb1(w_cdb1),
      .o_val (w_op2[g]),
      .o_rdy (w_op2r[g])
    );

    assign w_nxt[g] = {w_base[g][ENTRY_W-1:REGWRITE], w_op2[g], w_op2r[g],
                       w_op1[g], w_op1r[g], w_base[g][RD_HI:RD_LO]};
  end

  // Empty slots are kept all-zero so the outputs need no masking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_ent <= '0;
      r_rob <= '0;
      r_sel <= 1'b0;
    end else if (flush) begin
      r_vld <= '0;
      r_ent <= '0;
      r_rob <= '0;
      r_sel <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_dsp && w_tgt[i]) begin
          r_vld[i] <= 1'b1;
          r_ent[i] <= w_nxt[i];
          r_rob[i] <= dispatch_rob_num;
        end else if (w_iss[i]) begin
          r_vld[i] <= 1'b0;
          r_ent[i] <= '0;
          r_rob[i] <= '0;
        end else if (r_vld[i]) begin
          r_ent[i] <= w_nxt[i];
        end
      end
      if (w_dsp) r_sel <= w_tgt[1];
    end
  end

  assign rs_full                = w_full;
  assign rs_complex_0           = r_ent[0];
  assign rs_complex_1           = r_ent[1];
  assign rs_complex_0_entry_num = r_rob[0];
  assign rs_complex_1_entry_num = r_rob[1];
  assign selector               = r_sel;

`ifdef RS_COMPLEX_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if ((|w_iss) && (perf_issue_cnt != 16'hFFFF))
        perf_issue_cnt <= perf_issue_cnt + 16'd1;
      if (dispatch_valid && w_full && (perf_stall_cnt != 16'hFFFF))
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rs_complex.sv
// Directed bench for rs_complex: expected slot state is pushed onto a
// scoreboard queue as each step is driven and popped/compared after the edge.
module tb_rs_complex;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         dispatch_valid;
  logic [113:0] dispatch_entry;
  logic [3:0]   dispatch_rob_num;
  logic         rs_full;
  logic         cdb0_valid, cdb1_valid;
  logic [3:0]   cdb0_tag, cdb1_tag;
  logic [31:0]  cdb0_data, cdb1_data;
  logic         flush, complex_0_issue, complex_1_issue;
  logic [113:0] rs_complex_0, rs_complex_1;
  logic [3:0]   rs_complex_0_entry_num, rs_complex_1_entry_num;
  logic         selector;
`ifdef RS_COMPLEX_PERF_EN
  logic [15:0]  perf_issue_cnt, perf_stall_cnt;
`endif

  int nerr = 0;
  int nchk = 0;

  typedef struct {
    string        tag;
    logic [113:0] e0, e1;
    logic [3:0]   n0, n1;
    logic         sel, full;
  } exp_t;
  exp_t q[$];

  rs_complex dut (
    .clk(clk), .rst_n(rst_n),
    .dispatch_valid(dispatch_valid), .dispatch_entry(dispatch_entry),
    .dispatch_rob_num(dispatch_rob_num), .rs_full(rs_full),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .flush(flush), .complex_0_issue(complex_0_issue), .complex_1_issue(complex_1_issue),
    .rs_complex_0(rs_complex_0), .rs_complex_1(rs_complex_1),
    .rs_complex_0_entry_num(rs_complex_0_entry_num),
    .rs_complex_1_entry_num(rs_complex_1_entry_num),
    .selector(selector)
`ifdef RS_COMPLEX_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Entry builder with fixed non-operand fields so pass-through is visible.
  function automatic logic [113:0] mk(logic [31:0] o1, logic r1, logic [31:0] o2, logic r2,
                                      logic [4:0] rd);
    logic [113:0] e;
    e          = '0;
    e[113:82]  = 32'h1234_5600 | {27'd0, rd};
    e[81:76]   = 6'h2A;
    e[73]      = 1'b1;
    e[71]      = 1'b1;
    e[70:39]   = o2;
    e[38]      = r2;
    e[37:6]    = o1;
    e[5]       = r1;
    e[4:0]     = rd;
    return e;
  endfunction

  task automatic chk(string t, logic [113:0] obs, logic [113:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", t, obs, exp);
    end
  endtask

  task automatic push(string t, logic [113:0] e0, logic [3:0] n0, logic [113:0] e1,
                      logic [3:0] n1, logic sel, logic full);
    exp_t x;
    x.tag = t; x.e0 = e0; x.e1 = e1; x.n0 = n0; x.n1 = n1; x.sel = sel; x.full = full;
    q.push_back(x);
  endtask

  task automatic sb_check();
    exp_t x;
    if (q.size() == 0) begin
      nchk++; nerr++;
      $error("FAIL sb_empty: got no expectation want one");
    end else begin
      x = q.pop_front();
      chk({x.tag, ".e0"},   rs_complex_0, x.e0);
      chk({x.tag, ".e1"},   rs_complex_1, x.e1);
      chk({x.tag, ".n0"},   {110'd0, rs_complex_0_entry_num}, {110'd0, x.n0});
      chk({x.tag, ".n1"},   {110'd0, rs_complex_1_entry_num}, {110'd0, x.n1});
      chk({x.tag, ".sel"},  {113'd0, selector}, {113'd0, x.sel});
      chk({x.tag, ".full"}, {113'd0, rs_full},  {113'd0, x.full});
    end
  endtask

  task automatic idle();
    dispatch_valid = 0; dispatch_entry = '0; dispatch_rob_num = '0;
    cdb0_valid = 0; cdb0_tag = '0; cdb0_data = '0;
    cdb1_valid = 0; cdb1_tag = '0; cdb1_data = '0;
    flush = 0; complex_0_issue = 0; complex_1_issue = 0;
  endtask

  // Clock one edge with the currently driven inputs, check, return to idle.
  task automatic step(string t, logic [113:0] e0, logic [3:0] n0, logic [113:0] e1,
                      logic [3:0] n1, logic sel, logic full);
    push(t, e0, n0, e1, n1, sel, full);
    @(posedge clk); #1;
    sb_check();
    idle();
  endtask

  task automatic disp(logic [113:0] e, logic [3:0] rob);
    dispatch_valid = 1; dispatch_entry = e; dispatch_rob_num = rob;
  endtask

  logic [113:0] EA, EB, EC, ED, EE, Z;

  initial begin
    EA = mk(32'd5, 1, 32'd7, 1, 5'd2);
    EB = mk(32'd5, 1, 32'd9, 0, 5'd4);
    EC = mk(32'd1, 1, 32'd2, 1, 5'd1);
    ED = mk(32'd3, 1, 32'd4, 1, 5'd7);
    EE = mk(32'd12, 0, 32'd7, 1, 5'd3);
    Z  = '0;

    idle();
    rst_n = 0;
    #12;
    push("reset", Z, 0, Z, 0, 0, 0);
    sb_check();
    rst_n = 1;

    // basic dispatch, both operands ready
    disp(EA, 4'd3);                 step("disp",     EA, 3, Z, 0, 0, 0);
    complex_0_issue = 1;            step("iss0",     Z, 0, Z, 0, 0, 0);

    // wakeup from cdb1, then cdb0 priority over cdb1
    disp(EB, 4'd5);                 step("dispB",    EB, 5, Z, 0, 0, 0);
    cdb1_valid = 1; cdb1_tag = 4'd9; cdb1_data = 32'h0000_DEAD;
    step("wk_cdb1", mk(5, 1, 32'h0000_DEAD, 1, 4), 5, Z, 0, 0, 0);
    complex_0_issue = 1;            step("iss0b",    Z, 0, Z, 0, 0, 0);
    disp(EB, 4'd6);                 step("dispB2",   EB, 6, Z, 0, 0, 0);
    cdb0_valid = 1; cdb0_tag = 4'd9; cdb0_data = 32'h1;
    cdb1_valid = 1; cdb1_tag = 4'd9; cdb1_data = 32'h0000_DEAD;
    step("wk_prio", mk(5, 1, 32'h1, 1, 4), 6, Z, 0, 0, 0);
    complex_0_issue = 1;            step("iss0c",    Z, 0, Z, 0, 0, 0);

    // fill, drop while full, issue with dispatch, reuse of free slot
    disp(EC, 4'd1);                 step("fill0",    EC, 1, Z, 0, 0, 0);
    disp(ED, 4'd2);                 step("fill1",    EC, 1, ED, 2, 1, 1);
    disp(EA, 4'd7); cdb0_valid = 1; cdb0_tag = 4'd1; cdb0_data = 32'hFF;
    step("drop",     EC, 1, ED, 2, 1, 1);
    disp(EA, 4'd7); complex_0_issue = 1;
    step("iss_full", Z, 0, ED, 2, 1, 0);
    disp(EA, 4'd7); complex_1_issue = 1;
    step("iss_disp", EA, 7, Z, 0, 0, 0);
    complex_0_issue = 1; complex_1_issue = 1;
    step("iss_both", Z, 0, Z, 0, 0, 0);
    complex_1_issue = 1;            step("iss_empty", Z, 0, Z, 0, 0, 0);

    // dispatch-cycle bypass
    disp(EE, 4'd4); cdb0_valid = 1; cdb0_tag = 4'd12; cdb0_data = 32'hCAFE_0001;
    step("bypass", mk(32'hCAFE_0001, 1, 7, 1, 3), 4, Z, 0, 0, 0);
    complex_0_issue = 1;            step("iss0d",    Z, 0, Z, 0, 0, 0);

    // flush has priority over dispatch, issue and wakeup
    disp(EC, 4'd1);                 step("fill0b",   EC, 1, Z, 0, 0, 0);
    disp(ED, 4'd2);                 step("fill1b",   EC, 1, ED, 2, 1, 1);
    flush = 1; disp(EA, 4'd7); complex_1_issue = 1; cdb0_valid = 1; cdb0_tag = 4'd1;
    step("flush",    Z, 0, Z, 0, 0, 0);

    // asynchronous reset mid-operation
    disp(EA, 4'd3);                 step("disp_r",   EA, 3, Z, 0, 0, 0);
    #2 rst_n = 0;
    #1 push("async_rst", Z, 0, Z, 0, 0, 0);
    sb_check();
    rst_n = 1;

`ifdef RS_COMPLEX_PERF_EN
    chk("perf_issue_rst", {98'd0, perf_issue_cnt}, 114'd0);
    chk("perf_stall_rst", {98'd0, perf_stall_cnt}, 114'd0);
    disp(EC, 4'd1);                 step("p_fill0",  EC, 1, Z, 0, 0, 0);
    disp(ED, 4'd2);                 step("p_fill1",  EC, 1, ED, 2, 1, 1);
    for (int i = 0; i < 3; i++) begin
      disp(EA, 4'd7);               step("p_stall",  EC, 1, ED, 2, 1, 1);
    end
    complex_0_issue = 1;            step("p_iss0",   Z, 0, ED, 2, 1, 0);
    complex_1_issue = 1;            step("p_iss1",   Z, 0, Z, 0, 1, 0);
    chk("perf_stall3", {98'd0, perf_stall_cnt}, 114'd3);
    chk("perf_issue2", {98'd0, perf_issue_cnt}, 114'd2);
    disp(EC, 4'd1);                 step("p_fill0b", EC, 1, Z, 0, 0, 0);
    disp(ED, 4'd2);                 step("p_fill1b", EC, 1, ED, 2, 1, 1);
    disp(EA, 4'd7);
    repeat (65532) @(posedge clk);
    #1 chk("perf_stall_max", {98'd0, perf_stall_cnt}, 114'hFFFF);
    repeat (2) @(posedge clk);
    #1 chk("perf_stall_sat", {98'd0, perf_stall_cnt}, 114'hFFFF);
    chk("perf_issue_hold", {98'd0, perf_issue_cnt}, 114'd2);
    idle();
`endif

    if (q.size() != 0) begin
      nchk++; nerr++;
      $error("FAIL sb_leftover: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
